// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// Frame sequencing states used by fifo_uart_tx.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Per-bit clock divider for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each serial bit.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    assign bit_end = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from a registered-output FIFO.
// One word per frame: start, LSB-first data, optional even parity, stop.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx_serial,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shreg, shreg_next;
    logic [BW-1:0]         bit_cnt, bit_cnt_next;
    logic                  par;
    logic                  tx_next;
    logic                  bit_end;
    logic                  baud_clr;

    assign baud_clr   = (state == IDLE) || (state == FETCH);
    assign fifo_rd_en = (state == IDLE) & enable & ~fifo_empty & ~rst;
    assign busy       = (state != IDLE);
    assign tx_done    = (state == STOP) & bit_end & ~rst;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (baud_clr),
        .bit_end(bit_end)
    );

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = '0;
        unique case (state)
            IDLE: begin
                if (fifo_rd_en) state_next = FETCH;
            end
            FETCH: begin
                shreg_next = fifo_data;
                state_next = START;
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                bit_cnt_next = bit_cnt;
                if (bit_end) begin
                    shreg_next = shreg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level is registered from the upcoming state so it lines up with it.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            PARITY:  tx_next = par;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            par       <= 1'b0;
            tx_serial <= 1'b1;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            bit_cnt   <= bit_cnt_next;
            tx_serial <= tx_next;
            if (state == FETCH) par <= ^fifo_data;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at DATA_WIDTH=8, CLKS_PER_BIT=4.
// Second instance runs with even parity enabled on the same stimulus.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;

    logic rd_en, tx, busy, done;
    logic rd_en_p, tx_p, busy_p, done_p;

    int n_pass = 0;
    int n_checks = 0;

    logic [127:0] v_tx, v_rd, v_done, v_busy, v_tx_p, v_done_p;
    logic [127:0] e_tx, e_rd, e_done, e_busy;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(rd_en), .tx_serial(tx),
        .busy(busy), .tx_done(done)
    );

    fifo_uart_tx #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)
    ) dut_p (
        .clk(clk), .rst(rst), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(rd_en_p), .tx_serial(tx_p),
        .busy(busy_p), .tx_done(done_p)
    );

    task automatic check(input string tag,
                         input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Expected line level c cycles after the fifo_rd_en cycle.
    function automatic logic exp_tx(input logic [7:0] b, input int c,
                                    input bit par);
        if (c < 2) return 1'b1;
        if (c < 6) return 1'b0;
        if (c < 38) return b[(c - 6) / 4];
        if (par && c < 42) return ^b;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int c);
        #1;
        v_tx[c]     = tx;
        v_rd[c]     = rd_en;
        v_done[c]   = done;
        v_busy[c]   = busy;
        v_tx_p[c]   = tx_p;
        v_done_p[c] = done_p;
    endtask

    task automatic clear();
        v_tx = '0; v_rd = '0; v_done = '0; v_busy = '0;
        v_tx_p = '0; v_done_p = '0;
        e_tx = '0; e_rd = '0; e_done = '0; e_busy = '0;
    endtask

    task automatic start_frame(input logic [7:0] b);
        tick();
        fifo_data  = b;
        fifo_empty = 1'b0;
        enable     = 1'b1;
    endtask

    initial begin
        // Reset held with data available: nothing may move.
        rst = 1'b1; enable = 1'b1; fifo_empty = 1'b0; fifo_data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check($sformatf("reset_c%0d", i),
                  128'({tx, busy, rd_en, done}), 128'(4'b1000));
        end

        // Single 0xA5 frame.
        clear();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 44; c++) begin
            if (c > 0) tick();
            if (c == 1) fifo_empty = 1'b1;
            sample(c);
        end
        for (int c = 0; c < 44; c++) begin
            e_tx[c]   = exp_tx(8'hA5, c, 1'b0);
            e_busy[c] = (c >= 1 && c <= 41);
        end
        e_rd[0] = 1'b1;
        e_done[41] = 1'b1;
        check("a5_rd_en", v_rd, e_rd);
        check("a5_tx", v_tx, e_tx);
        check("a5_done", v_done, e_done);
        check("a5_busy", v_busy, e_busy);

        // Back-to-back 0x00 then 0xFF.
        clear();
        start_frame(8'h00);
        for (int c = 0; c < 88; c++) begin
            if (c > 0) tick();
            if (c == 2) fifo_data = 8'hFF;
            if (c == 43) fifo_empty = 1'b1;
            sample(c);
        end
        for (int c = 0; c < 88; c++) begin
            e_tx[c] = (c < 42) ? exp_tx(8'h00, c, 1'b0)
                               : exp_tx(8'hFF, c - 42, 1'b0);
            e_busy[c] = (c >= 1 && c <= 41) || (c >= 43 && c <= 83);
        end
        e_rd[0] = 1'b1; e_rd[42] = 1'b1;
        e_done[41] = 1'b1; e_done[83] = 1'b1;
        check("b2b_rd_en", v_rd, e_rd);
        check("b2b_tx", v_tx, e_tx);
        check("b2b_done", v_done, e_done);
        check("b2b_busy", v_busy, e_busy);

        // enable low blocks fetches even with data waiting.
        clear();
        tick();
        enable = 1'b0; fifo_empty = 1'b0; fifo_data = 8'h3C;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            sample(c);
        end
        check("dis_rd_en", v_rd, '0);
        check("dis_busy", v_busy, '0);

        // enable dropped mid-frame: frame completes, no refetch.
        clear();
        tick();
        enable = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) tick();
            if (c == 10) enable = 1'b0;
            sample(c);
        end
        for (int c = 0; c < 60; c++) e_tx[c] = exp_tx(8'h3C, c, 1'b0);
        e_rd[0] = 1'b1;
        e_done[41] = 1'b1;
        check("en_drop_rd_en", v_rd, e_rd);
        check("en_drop_tx", v_tx, e_tx);
        check("en_drop_done", v_done, e_done);

        // Reset in cycle 20 aborts the frame.
        clear();
        start_frame(8'h5A);
        for (int c = 0; c < 24; c++) begin
            if (c > 0) tick();
            if (c == 20) rst = 1'b1;
            if (c == 23) rst = 1'b0;
            sample(c);
        end
        e_rd[0] = 1'b1; e_rd[23] = 1'b1;
        check("rst_rd_en", v_rd, e_rd);
        check("rst_done", v_done, '0);
        check("rst_tx_hi", 128'(v_tx[22:21]), 128'(2'b11));
        check("rst_busy", 128'(v_busy[22:20]), 128'(3'b001));
        check("rst_p_done", v_done_p, '0);

        tick();
        rst = 1'b1; fifo_empty = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Parity instance with 0x07: parity bit 1, stop 42-45.
        clear();
        start_frame(8'h07);
        for (int c = 0; c < 48; c++) begin
            if (c > 0) tick();
            if (c == 1) fifo_empty = 1'b1;
            sample(c);
        end
        for (int c = 0; c < 48; c++) e_tx[c] = exp_tx(8'h07, c, 1'b1);
        e_done[45] = 1'b1;
        check("par_tx", v_tx_p, e_tx);
        check("par_done", v_done_p, e_done);
        check("par_bit", 128'(v_tx_p[41:38]), 128'(4'b1111));
        e_done = '0;
        e_done[41] = 1'b1;
        check("nopar_done", v_done, e_done);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each FIFO word and of the serial payload.
REQ-002 Parameter CLKS_PER_BIT, default 16, number of clk cycles per serial bit; legal values are 2 or greater.
REQ-003 Parameter PARITY_EN, default 0; 0 = no parity bit, 1 = even parity bit after the MSB.
REQ-004 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Port rst  input  1  reset; synchronous, active-high.
REQ-006 Port enable  input  1  permits new FIFO fetches when high.
REQ-007 Port fifo_empty  input  1  empty flag from the upstream FIFO.
REQ-008 Port fifo_data  input  DATA_WIDTH  registered FIFO read data; valid the cycle after the fifo_rd_en cycle.
REQ-009 Port fifo_rd_en  output  1  one-cycle read strobe to the FIFO.
REQ-010 Port tx_serial  output  1  serial line; idle-high.
REQ-011 Port busy  output  1  high whenever state is not IDLE.
REQ-012 Port tx_done  output  1  one-cycle pulse marking a completed frame.

Function
REQ-013 The FSM states SHALL be IDLE, FETCH, START, DATA, PARITY and STOP.
REQ-014 fifo_rd_en SHALL be combinational: (state==IDLE) & enable & !fifo_empty & !rst.
REQ-015 In IDLE, fifo_rd_en high -> next state FETCH; otherwise the FSM stays in IDLE.
REQ-016 In FETCH (exactly 1 cycle), the block SHALL latch fifo_data into the shift register and go to START.
REQ-017 START SHALL drive tx_serial=0 for CLKS_PER_BIT cycles; the first START cycle is 2 cycles after the fifo_rd_en cycle.
REQ-018 DATA SHALL shift out DATA_WIDTH bits LSB-first, each held for CLKS_PER_BIT cycles.
REQ-019 The PARITY state SHALL be entered only when PARITY_EN=1, and SHALL drive the XOR of the latched byte for CLKS_PER_BIT cycles.
REQ-020 STOP SHALL drive tx_serial=1 for CLKS_PER_BIT cycles; tx_done SHALL be high only in the last STOP cycle; the next state is IDLE.
REQ-021 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on every bit boundary; its width SHALL be $clog2(CLKS_PER_BIT).
REQ-022 The bit counter SHALL count 0..DATA_WIDTH-1 and clear on leaving DATA.
REQ-023 A frame in progress SHALL be unaffected by enable or fifo_empty changes; those inputs gate only the IDLE decision.
REQ-024 Back-to-back frames: the earliest next fifo_rd_en is the cycle after the last STOP cycle (IDLE), giving 2 idle-high cycles between frames.
REQ-025 tx_serial SHALL be driven from a register (glitch-free) and SHALL be 1 in IDLE and FETCH.

Reset
REQ-026 While rst is high at a clock edge: state=IDLE, tx_serial=1, busy=0, tx_done=0, counters=0, shift register=0.
REQ-027 A reset mid-frame SHALL abort the frame with no tx_done; the latched byte is discarded and not re-fetched.

Structure
REQ-028 Package fifo_uart_pkg SHALL hold the state-encoding typedef and the IDLE..STOP constants.
REQ-029 The baud counter SHALL be sub-module uart_baud_counter (CLKS_PER_BIT parameter, clr input, bit_end output); the FSM and shift register SHALL remain in fifo_uart_tx.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4, cycle 0 = fifo_rd_en cycle)
REQ-030 Hold rst for 3 cycles with fifo_empty=0 and enable=1 -> tx_serial=1, busy=0, fifo_rd_en=0, tx_done=0 throughout.
REQ-031 Single byte 0xA5 -> tx low cycles 2-5; bits 1,0,1,0,0,1,0,1 over cycles 6-37; stop high 38-41; tx_done in cycle 41 only.
REQ-032 Bytes 0x00 then 0xFF queued -> second fifo_rd_en in cycle 42; second start bit begins in cycle 44.
REQ-033 enable=0 with fifo_empty=0 -> no fifo_rd_en; enable dropped in cycle 10 -> frame completes, no further fetch.
REQ-034 rst asserted in cycle 20 -> tx_serial=1 and busy=0 from cycle 21; no tx_done; fifo_rd_en is only reissued once rst is low.
REQ-035 PARITY_EN=1, byte 0x07 -> parity bit 1 in cycles 38-41; stop in cycles 42-45; tx_done in cycle 45.
